dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the target end of the core's load/store port (`daddr`, `dwdata`, `we`). It accepts one request at a time over a req/ack handshake, applies a configurable number of wait states, and serves a word-organised RAM with byte-lane writes plus two memory-mapped registers (a free-running cycle counter and a general output register). It replaces the zero-latency data memory when the core runs against realistic memory timing.

## Interface
- `DEPTH_WORDS`, 1024, RAM size in 32-bit words; power of two.
- `WAIT_STATES`, 1, extra cycles between request capture and response; range 0–15.
- `MMIO_BASE`, 32'h8000_0000, byte base of the MMIO window; 8-byte aligned.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid; held by the initiator until `ack`.
- `daddr`  in  32  byte address.
- `dwdata`  in  32  write data, lane-replicated by the core (byte → 4 copies, half → 2 copies).
- `we`  in  4  byte-lane write enables; 4'b0000 means read.
- `drdata`  out  32  read data; valid only while `ack`=1.
- `ack`  out  1  one-cycle response strobe.
- `err`  out  1  error flag; valid only while `ack`=1.
- `mmio_out`  out  32  contents of the output register.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE with `req`=1: capture `daddr`/`dwdata`/`we`, load the wait counter with `WAIT_STATES`. Next state is WAIT if `WAIT_STATES`>0, else RESP.
  - WAIT: decrement the counter; when it reaches 1, go to RESP.
  - RESP: `ack`=1 for exactly one cycle, then IDLE.
- Changes on `req`/`daddr`/`dwdata`/`we` outside IDLE are ignored. Requests are never queued.
- Address decode on the captured address:
  - RAM hit: `daddr` < 4·`DEPTH_WORDS`. Word index is `daddr[log2(DEPTH_WORDS)+1:2]`. Bits [1:0] are ignored for reads; the full word is returned and the core extracts the byte or halfword.
  - MMIO +0: cycle counter, read-only. Writes are silently dropped with `err`=0.
  - MMIO +4: output register. Writable per byte lane; drives `mmio_out`.
  - Any other address: `err`=1, `drdata`=0, no state change.
- Legal `we` values: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value gives `err`=1 and no write.
- Writes update only the enabled lanes, taking each lane from the same lane of `dwdata`. For writes, `drdata`=0.
- Cycle counter: 32 bits, 0 in the first cycle after reset, +1 every cycle, wraps 0xFFFF_FFFF → 0. Counts in every FSM state.

## Timing
- Request sampled in IDLE cycle T. WAIT occupies cycles T+1..T+`WAIT_STATES`. RESP (ack high) is cycle T+`WAIT_STATES`+1.
- The write commit and the read-data register load both happen on the edge that enters RESP. The counter value returned is the count in the cycle just before RESP.
- Minimum request spacing is `WAIT_STATES`+2 cycles. The initiator must drop `req` in the cycle after `ack`; otherwise IDLE captures a new request.
- Reset values: state IDLE, `ack`=0, `err`=0, `drdata`=0, `mmio_out`=0, counter 0. RAM contents are not reset.
- Reset asserted during WAIT or RESP aborts the transaction. A write not yet committed is never committed. `ack` is 0 in the cycle after reset.
- `err`/`drdata` are 0 whenever `ack`=0.

## Test plan
- `WAIT_STATES`=1: write 0xDEADBEEF, `we`=1111 @0x40 (req cycle 2) → `ack` cycle 4, `err`=0. Then read @0x40 → `drdata`=0xDEADBEEF, `ack` exactly 2 cycles after capture.
- After the above, byte write `we`=0100, `dwdata`=0xABABABAB @0x42, then read @0x40 → 0xDEABBEEF. Read @0x43 → same word.
- Illegal `we`=0101 @0x40 → `ack`=1, `err`=1, RAM unchanged. Read @4·`DEPTH_WORDS` → `err`=1, `drdata`=0. Read @`MMIO_BASE`+8 → `err`=1.
- Read `MMIO_BASE` with req in cycle 5 after reset, `WAIT_STATES`=1 → `drdata`=6 in cycle 7. Write 0x1234 to `MMIO_BASE` → `err`=0, counter unaffected.
- Write 0x0000_00FF `we`=0001 to `MMIO_BASE`+4 → `mmio_out`=0x0000_00FF from cycle after commit. `we`=1100, `dwdata`=0x5A5A5A5A → `mmio_out`=0x5A5A_00FF.
- `WAIT_STATES`=3: write 0x1 @0x80, assert `reset` in the second WAIT cycle → no `ack`, `mmio_out`=0. Later read @0x80 returns the prior contents, not 0x1.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic        ack;
  logic        err;

  modport master (output req, daddr, dwdata, we, input drdata, ack, err);
  modport slave  (input req, daddr, dwdata, we, output drdata, ack, err);
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: word RAM with byte lanes, a cycle counter and an
// output register in a small MMIO window, one request at a time over req/ack.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [31:0]       mmio_out
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [29:0] CNT_WADDR = MMIO_BASE[31:2];
  localparam logic [29:0] OUT_WADDR = MMIO_BASE[31:2] + 30'd1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic legal_we(input logic [3:0] lanes);
    case (lanes)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: legal_we = 1'b1;
      default:                             legal_we = 1'b0;
    endcase
  endfunction

  state_t      state_r, next_state_s;
  logic [3:0]  wcnt_r;
  logic [31:0] cnt_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  we_r;
  logic        ack_r, err_r;
  logic [31:0] drdata_r, out_r;
  logic [31:0] mem [DEPTH_WORDS];

  logic          capture_s, commit_s;
  logic [31:0]   src_addr_s, src_wdata_s, rdata_s;
  logic [3:0]    src_we_s, ram_we_s, out_we_s;
  logic [AW-1:0] idx_s;
  logic          ram_hit_s, cnt_hit_s, out_hit_s, wr_s, bad_s;

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) begin
          capture_s = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            next_state_s = ST_RESP;
            commit_s     = 1'b1;
          end else begin
            next_state_s = ST_WAIT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_r <= 4'd1) begin
          next_state_s = ST_RESP;
          commit_s     = 1'b1;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the capture edge, so use live inputs in IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      src_addr_s  = bus.daddr;
      src_wdata_s = bus.dwdata;
      src_we_s    = bus.we;
    end else begin
      src_addr_s  = addr_r;
      src_wdata_s = wdata_r;
      src_we_s    = we_r;
    end
  end

  // Address decode, error detection and read-data selection.
  always_comb begin
    idx_s     = src_addr_s[AW+1:2];
    ram_hit_s = (src_addr_s < RAM_BYTES);
    cnt_hit_s = (src_addr_s[31:2] == CNT_WADDR);
    out_hit_s = (src_addr_s[31:2] == OUT_WADDR);
    wr_s      = (src_we_s != 4'b0000);
    bad_s     = !legal_we(src_we_s) || !(ram_hit_s || cnt_hit_s || out_hit_s);
    rdata_s   = 32'd0;
    if (bad_s || wr_s) begin
      rdata_s = 32'd0;
    end else if (ram_hit_s) begin
      rdata_s = mem[idx_s];
    end else if (cnt_hit_s) begin
      rdata_s = cnt_r;
    end else if (out_hit_s) begin
      rdata_s = out_r;
    end else begin
      rdata_s = 32'd0;
    end
    ram_we_s = (commit_s && ram_hit_s && !bad_s && !reset) ? src_we_s : 4'b0000;
    out_we_s = (commit_s && out_hit_s && !bad_s && !reset) ? src_we_s : 4'b0000;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture, wait counter, cycle counter and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_r   <= 4'd0;
      cnt_r    <= 32'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      we_r     <= 4'd0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      drdata_r <= 32'd0;
      out_r    <= 32'd0;
    end else begin
      cnt_r <= cnt_r + 32'd1;
      if (capture_s) begin
        addr_r  <= bus.daddr;
        wdata_r <= bus.dwdata;
        we_r    <= bus.we;
        wcnt_r  <= WAIT_INIT;
      end else if (state_r == ST_WAIT) begin
        wcnt_r <= wcnt_r - 4'd1;
      end
      ack_r    <= commit_s;
      err_r    <= commit_s && bad_s;
      drdata_r <= commit_s ? rdata_s : 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (out_we_s[i]) out_r[8*i +: 8] <= src_wdata_s[8*i +: 8];
      end
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s[i]) mem[idx_s][8*i +: 8] <= src_wdata_s[8*i +: 8];
    end
  end

  assign bus.ack    = ack_r;
  assign bus.err    = err_r;
  assign bus.drdata = drdata_r;
  assign mmio_out   = out_r;

endmodule
